// File: rtl/int_latch_encoder.sv
// Sticky interrupt latch with mask and priority encoder; holds one request until ACK.
// Optional ack timeout is built only when INT_TIMEOUT_EN is defined.
module int_latch_encoder #(
  parameter int NSRC    = 8,
  parameter int CODE_W  = 3,
  parameter int TMO_CNT = 15
) (
  input  logic              SIM_CLK,
  input  logic              SIM_RST,
  input  logic              V1,
  input  logic [NSRC-1:0]   INTSRC,
  input  logic              MASK_WR,
  input  logic [NSRC-1:0]   MASK_D,
  input  logic              ACK,
  output logic              INTREQ,
  output logic [CODE_W-1:0] INTCODE,
  output logic [NSRC-1:0]   PEND,
  output logic              OVRN,
  output logic              TMO
);

  typedef enum logic [1:0] {IDLE, REQ, CLR} state_t;

  if ((1 << CODE_W) < NSRC) begin : g_bad_code_w
    $error("CODE_W too narrow for NSRC");
  end
  if (TMO_CNT < 1 || TMO_CNT > 15) begin : g_bad_tmo_cnt
    $error("TMO_CNT must fit the 4-bit timeout counter");
  end

  function automatic logic [CODE_W-1:0] lowest_index(input logic [NSRC-1:0] vec);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (vec[i]) idx = CODE_W'(i);
    end
    return idx;
  endfunction

  state_t            state, state_nxt;
  logic [NSRC-1:0]   mask;
  logic [NSRC-1:0]   prev;
  logic [NSRC-1:0]   rise;
  logic [NSRC-1:0]   clr;
  logic [NSRC-1:0]   pend_nxt;
  logic [NSRC-1:0]   req_vec;
  logic [CODE_W-1:0] code_nxt;
  logic              tmo_hit;

  assign rise     = INTSRC & ~prev;
  assign req_vec  = PEND & mask;
  // A rise on the bit being cleared must survive, so rise is OR'd in after the clear.
  assign pend_nxt = (PEND & ~clr) | rise;
  assign INTREQ   = (state == REQ);

  always_comb begin
    state_nxt = state;
    code_nxt  = INTCODE;
    clr       = '0;
    if (V1) begin
      case (state)
        IDLE: begin
          if (|req_vec) begin
            state_nxt = REQ;
            code_nxt  = lowest_index(req_vec);
          end
        end
        REQ: begin
          if (ACK)          state_nxt = CLR;
          else if (tmo_hit) state_nxt = IDLE;
        end
        CLR: begin
          clr       = {{(NSRC-1){1'b0}}, 1'b1} << INTCODE;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      state   <= IDLE;
      INTCODE <= '0;
      PEND    <= '0;
      prev    <= '0;
      mask    <= '0;
      OVRN    <= 1'b0;
    end else begin
      state   <= state_nxt;
      INTCODE <= code_nxt;
      if (MASK_WR) begin
        mask <= MASK_D;
        OVRN <= 1'b0;
      end
      if (V1) begin
        prev <= INTSRC;
        PEND <= pend_nxt;
        if (|(rise & PEND)) OVRN <= 1'b1;
      end
    end
  end

`ifdef INT_TIMEOUT_EN
  logic [3:0] tmo_cnt;

  assign tmo_hit = (state == REQ) && (tmo_cnt == 4'(TMO_CNT - 1));

  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      tmo_cnt <= '0;
      TMO     <= 1'b0;
    end else begin
      if (MASK_WR) TMO <= 1'b0;
      if (V1) begin
        if (state == IDLE && state_nxt == REQ) begin
          tmo_cnt <= '0;
        end else if (state == REQ && !ACK) begin
          tmo_cnt <= tmo_cnt + 4'd1;
          if (tmo_hit) TMO <= 1'b1;
        end
      end
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign TMO     = 1'b0;
`endif

endmodule
